pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Parametrised program-counter and fetch sequencer for the ARM-subset core, replacing the fixed 32-bit PC register.
- Priority-resolves the next PC from these sources: reset vector, writeback redirect, return, branch, stall, sequential increment.
- Takes signed word-offset branches with pipeline bias and keeps a DEPTH-entry return-address stack (RAS) for call/return.
- After every redirect, raises a flush window of FLUSH_CYCLES cycles so downstream stages squash wrong-path instructions.

Parameters:
WIDTH, 32, PC / data width in bits
IMM_WIDTH, 24, branch immediate width; signed word offset
RESET_VECTOR, 0, PC value loaded on reset
PIPE_BIAS, 8, constant added to the current PC for branch targets (ARM PC+8)
DEPTH, 4, RAS entries (power of two, >=2)
FLUSH_CYCLES, 2, cycles fetchValid stays low after a redirect (>=1)

Ports:
clk  in  1  rising-edge clock
Reset  in  1  synchronous, active-low reset (sampled on posedge clk)
stall  in  1  hold the PC; ignored when any redirect source is active
Branch  in  1  take branch to currData+PIPE_BIAS+(sext(branchImmediate)<<2)
branchLink  in  1  with Branch: push currData+4 onto the RAS (call)
ret  in  1  pop the RAS and jump to the popped address
branchImmediate  in  IMM_WIDTH  signed word offset
writeEnable  in  1  writeback redirect (write to PC register)
writeData  in  WIDTH  redirect target
currData  out  WIDTH  current fetch PC
fetchValid  out  1  currData is a valid (non-squashed) fetch
flush  out  1  squash younger pipeline stages this cycle
rasOverflow  out  1  sticky: a push overwrote a live entry
rasUnderflow  out  1  sticky: ret issued with the RAS empty

Behaviour:
- Reset (Reset==0 at posedge):
  - currData=RESET_VECTOR, fetchValid=0, flush=0, state=BOOT.
  - RAS count=0, pointer=0, both sticky flags=0.
  - Reset overrides every other input, including mid-flush.
- State machine: BOOT -> RUN after 1 cycle. RUN -> FLUSH on any redirect. FLUSH -> RUN when flushCnt reaches 0. A redirect while in FLUSH reloads flushCnt=FLUSH_CYCLES and stays in FLUSH.
- fetchValid=1 only in RUN; 0 in BOOT and FLUSH. flush=1 only in FLUSH.
- Next-PC priority, highest first:
  - writeEnable: writeData.
  - ret with RAS non-empty: top of stack (pop).
  - Branch: target.
  - stall: currData.
  - otherwise: currData+4.
- A redirect is writeEnable, a ret that pops, or Branch. stall never blocks a redirect.
- Arithmetic:
  - sext extends branchImmediate to WIDTH, then shifts left by 2 with truncation to WIDTH.
  - All additions are modulo 2^WIDTH; the PC wraps silently.
  - currData+4 at 2^WIDTH-4 gives 0.
- Latency: the new PC appears on currData one cycle after the cycle the source is sampled.
- RAS push (Branch & branchLink, and Branch wins arbitration):
  - Writes currData+4 at the pointer, then pointer++ (mod DEPTH).
  - count saturates at DEPTH.
  - Push while full overwrites the oldest entry and sets rasOverflow.
- RAS pop (ret, and no writeEnable): pointer--, count--, PC=popped value.
- ret with count==0:
  - No pop, no redirect from ret, rasUnderflow set.
  - Lower-priority sources (Branch/stall/increment) apply normally.
- ret and Branch both asserted: ret wins. Branch and branchLink are ignored (no push).
- writeEnable with ret/Branch: writeData wins; the RAS is not modified.
- branchLink without Branch: ignored.
- Sticky flags clear only on reset.

Test Plan:
1. Reset low 2 cycles, then high, no other inputs -> currData=0 with fetchValid=0 for 1 cycle (BOOT), then 4, 8, 12 with fetchValid=1.
2. At PC=0x100, Branch=1, imm=0xFFFFFE (-2) -> next PC=0x100; flush=1 for 2 cycles; fetchValid returns to 1 on the third cycle.
3. At PC=0x40, Branch+branchLink, imm=4 -> PC=0x58 and 0x44 pushed. Later ret -> PC=0x44, count=0, no flags.
4. DEPTH=4: 5 calls pushing 0x04/0x14/0x24/0x34/0x44 -> rasOverflow=1. 4 rets yield 0x44, 0x34, 0x24, 0x14. A 5th ret with the RAS empty -> rasUnderflow=1 and PC increments by 4.
5. stall=1 at PC=0x20 for 3 cycles -> PC holds at 0x20. Then stall=1 together with writeEnable, writeData=0x800 -> PC=0x800, flush asserted.
6. PC=0xFFFFFFFC with no inputs -> 0x0. Mid-flush Reset=0 -> currData=RESET_VECTOR, flush=0, fetchValid=0 on the next edge.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between the core front end (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int WIDTH     = 32,
    parameter int IMM_WIDTH = 24
);
    logic                 stall;
    logic                 Branch;
    logic                 branchLink;
    logic                 ret;
    logic [IMM_WIDTH-1:0] branchImmediate;
    logic                 writeEnable;
    logic [WIDTH-1:0]     writeData;
    logic [WIDTH-1:0]     currData;
    logic                 fetchValid;
    logic                 flush;
    logic                 rasOverflow;
    logic                 rasUnderflow;

    modport master (
        output stall, Branch, branchLink, ret, branchImmediate, writeEnable, writeData,
        input  currData, fetchValid, flush, rasOverflow, rasUnderflow
    );

    modport slave (
        input  stall, Branch, branchLink, ret, branchImmediate, writeEnable, writeData,
        output currData, fetchValid, flush, rasOverflow, rasUnderflow
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program-counter / fetch sequencer: prioritised next-PC select, return-address stack,
// and a post-redirect flush window that squashes wrong-path fetches.
module pc_sequencer #(
    parameter int               WIDTH        = 32,
    parameter int               IMM_WIDTH    = 24,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               PIPE_BIAS    = 8,
    parameter int               DEPTH        = 4,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic             clk,
    input  logic             Reset,
    pc_sequencer_if.slave    bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int FC_W  = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FC_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             flush_q, flush_d;
    logic [WIDTH-1:0] ras_q [DEPTH];
    logic [WIDTH-1:0] ras_d [DEPTH];
    logic [PTR_W-1:0] ras_ptr_q, ras_ptr_d;
    logic [CNT_W-1:0] ras_cnt_q, ras_cnt_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    logic             ras_empty_s;
    logic             do_pop_s;
    logic             do_branch_s;
    logic             do_push_s;
    logic             redirect_s;
    logic [WIDTH-1:0] pc_plus4_s;
    logic [WIDTH-1:0] imm_sext_s;
    logic [WIDTH-1:0] target_s;
    logic [PTR_W-1:0] pop_ptr_s;

    // Source arbitration: writeback beats a live pop, which beats a branch.
    always_comb begin
        ras_empty_s = (ras_cnt_q == CNT_W'(0));
        do_pop_s    = bus.ret & ~bus.writeEnable & ~ras_empty_s;
        do_branch_s = bus.Branch & ~bus.writeEnable & ~do_pop_s;
        do_push_s   = do_branch_s & bus.branchLink;
        redirect_s  = bus.writeEnable | do_pop_s | do_branch_s;
        pc_plus4_s  = pc_q + WIDTH'(4);
        imm_sext_s  = {{(WIDTH-IMM_WIDTH){bus.branchImmediate[IMM_WIDTH-1]}}, bus.branchImmediate};
        target_s    = pc_q + WIDTH'(PIPE_BIAS) + (imm_sext_s << 2'd2);
        pop_ptr_s   = ras_ptr_q - PTR_W'(1);
    end

    // Next-PC select.
    always_comb begin
        pc_d = pc_plus4_s;
        if (bus.writeEnable) begin
            pc_d = bus.writeData;
        end else if (do_pop_s) begin
            pc_d = ras_q[pop_ptr_s];
        end else if (do_branch_s) begin
            pc_d = target_s;
        end else if (bus.stall) begin
            pc_d = pc_q;
        end else begin
            pc_d = pc_plus4_s;
        end
    end

    // Return-address stack update; a push when full overwrites the oldest slot.
    always_comb begin
        ras_d     = ras_q;
        ras_ptr_d = ras_ptr_q;
        ras_cnt_d = ras_cnt_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q | (bus.ret & ~bus.writeEnable & ras_empty_s);
        if (do_push_s) begin
            ras_d[ras_ptr_q] = pc_plus4_s;
            ras_ptr_d        = ras_ptr_q + PTR_W'(1);
            if (ras_cnt_q == CNT_W'(DEPTH)) begin
                ovf_d = 1'b1;
            end else begin
                ras_cnt_d = ras_cnt_q + CNT_W'(1);
            end
        end else if (do_pop_s) begin
            ras_ptr_d = pop_ptr_s;
            ras_cnt_d = ras_cnt_q - CNT_W'(1);
        end else begin
            ras_ptr_d = ras_ptr_q;
        end
    end

    // Fetch state machine; the flush counter holds the FLUSH cycles still to come.
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        if (redirect_s) begin
            state_d     = ST_FLUSH;
            flush_cnt_d = FC_W'(FLUSH_CYCLES - 1);
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    state_d = ST_RUN;
                end
                ST_FLUSH: begin
                    if (flush_cnt_q == FC_W'(0)) begin
                        state_d = ST_RUN;
                    end else begin
                        flush_cnt_d = flush_cnt_q - FC_W'(1);
                    end
                end
                default: begin
                    state_d     = ST_BOOT;
                    flush_cnt_d = FC_W'(0);
                end
            endcase
        end
        fetch_valid_d = (state_d == ST_RUN);
        flush_d       = (state_d == ST_FLUSH);
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q       <= ST_BOOT;
            flush_cnt_q   <= FC_W'(0);
            pc_q          <= RESET_VECTOR;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            ras_q         <= '{default: '0};
            ras_ptr_q     <= PTR_W'(0);
            ras_cnt_q     <= CNT_W'(0);
            ovf_q         <= 1'b0;
            unf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            flush_cnt_q   <= flush_cnt_d;
            pc_q          <= pc_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            ras_q         <= ras_d;
            ras_ptr_q     <= ras_ptr_d;
            ras_cnt_q     <= ras_cnt_d;
            ovf_q         <= ovf_d;
            unf_q         <= unf_d;
        end
    end

    assign bus.currData     = pc_q;
    assign bus.fetchValid   = fetch_valid_q;
    assign bus.flush        = flush_q;
    assign bus.rasOverflow  = ovf_q;
    assign bus.rasUnderflow = unf_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer with hand-computed expected values.
module tb_pc_sequencer;
    logic clk;
    logic reset_n;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic        stall;
        logic        br;
        logic        bl;
        logic        rt;
        logic        we;
        logic [23:0] imm;
        logic [31:0] wd;
        logic [31:0] pc;
        logic        fv;
        logic        fl;
        logic        ovf;
        logic        unf;
    } vec_t;

    vec_t vecs[$];

    pc_sequencer_if #(.WIDTH(32), .IMM_WIDTH(24)) bus ();

    pc_sequencer #(
        .WIDTH(32), .IMM_WIDTH(24), .RESET_VECTOR(32'h0),
        .PIPE_BIAS(8), .DEPTH(4), .FLUSH_CYCLES(2)
    ) dut (
        .clk   (clk),
        .Reset (reset_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input logic s, input logic br, input logic bl, input logic rt,
                                input logic we, input logic [23:0] imm, input logic [31:0] wd,
                                input logic [31:0] pc, input logic fv, input logic fl,
                                input logic ovf, input logic unf);
        vec_t v;
        v.stall = s;  v.br = br; v.bl = bl; v.rt = rt; v.we = we;
        v.imm = imm;  v.wd = wd; v.pc = pc; v.fv = fv; v.fl = fl;
        v.ovf = ovf;  v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic s, input logic br, input logic bl, input logic rt,
                         input logic we, input logic [23:0] imm, input logic [31:0] wd);
        bus.stall = s; bus.Branch = br; bus.branchLink = bl; bus.ret = rt;
        bus.writeEnable = we; bus.branchImmediate = imm; bus.writeData = wd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] pc, input logic fv,
                             input logic fl, input logic ovf, input logic unf);
        check({tag, " pc"},  bus.currData, pc);
        check({tag, " fv"},  {31'd0, bus.fetchValid}, {31'd0, fv});
        check({tag, " fl"},  {31'd0, bus.flush}, {31'd0, fl});
        check({tag, " ovf"}, {31'd0, bus.rasOverflow}, {31'd0, ovf});
        check({tag, " unf"}, {31'd0, bus.rasUnderflow}, {31'd0, unf});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        //                   s    br   bl   rt   we   imm         wd            pc            fv   fl   ovf  unf
        // boot then sequential increment
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000004,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000008,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h0000000C,1'b1,1'b0,1'b0,1'b0));
        // negative branch at 0x100 lands on 0x100
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,32'h00000100,  32'h00000100,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000100,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000100,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b0,1'b0,24'hFFFFFE,32'h0,         32'h00000100,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000104,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000108,1'b1,1'b0,1'b0,1'b0));
        // call at 0x40 then return
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,32'h00000040,  32'h00000040,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000004,32'h0,         32'h00000058,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h0000005C,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000060,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000044,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000048,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h0000004C,1'b1,1'b0,1'b0,1'b0));
        // stall holds; stall never blocks writeback or branch
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,32'h00000020,  32'h00000020,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000020,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000020,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000020,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b0,1'b0,1'b0,1'b1,24'h000000,32'h00000800,  32'h00000800,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000804,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000808,1'b1,1'b0,1'b0,1'b0));
        vecs.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000810,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000814,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000818,1'b1,1'b0,1'b0,1'b0));
        // five back-to-back calls overflow a 4-entry stack
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b1,24'h000000,32'h00000000,  32'h00000000,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000002,32'h0,         32'h00000010,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000002,32'h0,         32'h00000020,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000002,32'h0,         32'h00000030,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000002,32'h0,         32'h00000040,1'b0,1'b1,1'b0,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b0,1'b0,24'h000002,32'h0,         32'h00000050,1'b0,1'b1,1'b1,1'b0));
        // writeback beats ret (no pop); ret beats branch+link (no push)
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,24'h000000,32'h00000200,  32'h00000200,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b1,1'b1,1'b1,1'b0,24'h000000,32'h0,         32'h00000044,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000034,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000024,1'b0,1'b1,1'b1,1'b0));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000014,1'b0,1'b1,1'b1,1'b0));
        // empty-stack ret: underflow, falls through to increment / branch
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000018,1'b0,1'b1,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h0000001C,1'b1,1'b0,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b1,1'b0,1'b1,1'b0,24'h000000,32'h0,         32'h00000024,1'b0,1'b1,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h00000028,1'b0,1'b1,1'b1,1'b1));
        vecs.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,24'h000000,32'h0,         32'h0000002C,1'b1,1'b0,1'b1,1'b1));

        // reset held two cycles
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        tick();
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].stall, vecs[i].br, vecs[i].bl, vecs[i].rt, vecs[i].we,
                  vecs[i].imm, vecs[i].wd);
            tick();
            check_all($sformatf("v%0d", i), vecs[i].pc, vecs[i].fv, vecs[i].fl,
                      vecs[i].ovf, vecs[i].unf);
        end

        // wrap at the top of the address space
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 24'h0, 32'hFFFFFFFC);
        tick();
        check_all("wrap_load", 32'hFFFFFFFC, 1'b0, 1'b1, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        check_all("wrap", 32'h00000000, 1'b0, 1'b1, 1'b1, 1'b1);

        // reset mid-flush overrides concurrent redirects and clears sticky flags
        reset_n = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 24'h000010, 32'h00000123);
        tick();
        check_all("midflush_rst", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 32'h0);
        tick();
        check_all("post_rst", 32'h00000004, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
